// File: rtl/video_timing_ctrl.sv
// Video timing controller: ZX-UNO index/data register window holding shadow
// sync offsets and machine mode, copied to the active outputs only at a frame
// boundary when a commit is pending.
// Optional feature macro: BUTTON_NUDGE_EN (debounced buttons nudge the
// shadow hinit of the active mode by +/-1 and request a commit).
module video_timing_ctrl #(
  parameter logic [7:0]  IDX_ADDR        = 8'hC1,
  parameter logic [7:0]  DATA_ADDR       = 8'hC2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regwr,
  input  logic       zxuno_regrd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic [8:0] hinit48k,
  output logic [8:0] vinit48k,
  output logic [8:0] hinit128k,
  output logic [8:0] vinit128k,
  output logic [8:0] hinitpen,
  output logic [8:0] vinitpen,
  output logic       pending
);

  // Offset slots: 0 h48k, 1 v48k, 2 h128k, 3 v128k, 4 hpen, 5 vpen.
  localparam logic [5:0][8:0] RstOffsets = {9'd0, 9'd104, 9'd0, 9'd104, 9'd0, 9'd104};

  logic [3:0]      idx_q;
  logic [1:0]      mode_sh_q, mode_sh_d, mode_q;
  logic            pending_q, pending_d;
  logic [5:0][8:0] sh_q, sh_d, act_q;

  logic       idx_hit, data_hit, idx_wr, data_wr, data_acc, boundary;
  logic [3:0] idx_m1;
  logic [2:0] slot;
  logic       slot_valid, commit_set;
  logic [7:0] rd_data;
  logic       nudge_up, nudge_dn;
  logic [2:0] nudge_slot;
  logic       nudge_apply;

  assign idx_hit    = (zxuno_addr == IDX_ADDR);
  assign data_hit   = (zxuno_addr == DATA_ADDR);
  assign idx_wr     = zxuno_regwr && idx_hit;
  assign data_wr    = zxuno_regwr && data_hit;
  assign data_acc   = (zxuno_regwr || zxuno_regrd) && data_hit;
  assign boundary   = clken && (hcnt == 9'd0) && (vcnt == 9'd0);
  assign idx_m1     = idx_q - 4'd1;
  assign slot       = idx_m1[3:1];
  assign slot_valid = (idx_q != 4'd0) && (idx_q <= 4'd12);
  assign commit_set = data_wr && (idx_q == 4'd0) && din[7];

`ifdef BUTTON_NUDGE_EN
  logic [1:0]       sync1_q, sync2_q, stable_q, rise_q;
  logic [1:0][15:0] cnt_q;

  // Synchronise, debounce over clken cycles, and pulse on accepted 0->1 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      stable_q <= 2'b00;
      rise_q   <= 2'b00;
      cnt_q    <= '0;
    end else begin
      sync1_q <= {btn_down, btn_up};
      sync2_q <= sync1_q;
      rise_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (clken) begin
          if (sync2_q[i] == stable_q[i]) begin
            cnt_q[i] <= 16'd0;
          end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
            stable_q[i] <= sync2_q[i];
            rise_q[i]   <= sync2_q[i];
            cnt_q[i]    <= 16'd0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
          end
        end
      end
    end
  end

  assign nudge_up = rise_q[0];
  assign nudge_dn = rise_q[1];
`else
  logic unused_btn;
  assign unused_btn = btn_up ^ btn_down;
  assign nudge_up   = 1'b0;
  assign nudge_dn   = 1'b0;
`endif

  // Nudge targets the hinit of the active mode; a same-slot register write wins.
  assign nudge_slot  = (mode_q == 2'b01) ? 3'd2 : (mode_q[1] ? 3'd4 : 3'd0);
  assign nudge_apply = (nudge_up ^ nudge_dn) &&
                       !(data_wr && slot_valid && (slot == nudge_slot));

  // Next shadow state from nudges and data-window writes.
  always_comb begin
    sh_d      = sh_q;
    mode_sh_d = mode_sh_q;
    if (nudge_apply) begin
      sh_d[nudge_slot] = nudge_up ? sh_q[nudge_slot] + 9'd1 : sh_q[nudge_slot] - 9'd1;
    end
    if (data_wr) begin
      if (idx_q == 4'd0) begin
        mode_sh_d = din[1:0];
      end else if (slot_valid) begin
        if (idx_q[0]) sh_d[slot][7:0] = din;
        else          sh_d[slot][8]   = din[0];
      end
    end
  end

  // A boundary consumes the old pending; a same-cycle request re-arms it.
  always_comb begin
    pending_d = pending_q;
    if (boundary && pending_q) pending_d = 1'b0;
    if (commit_set || nudge_apply) pending_d = 1'b1;
  end

  // Register state; active copy takes pre-write shadow values at the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 4'd0;
      mode_sh_q <= 2'b00;
      mode_q    <= 2'b00;
      pending_q <= 1'b0;
      sh_q      <= RstOffsets;
      act_q     <= RstOffsets;
    end else begin
      if (idx_wr)        idx_q <= din[3:0];
      else if (data_acc) idx_q <= idx_q + 4'd1;
      if (boundary && pending_q) begin
        act_q  <= sh_q;
        mode_q <= mode_sh_q;
      end
      sh_q      <= sh_d;
      mode_sh_q <= mode_sh_d;
      pending_q <= pending_d;
    end
  end

  // Data-window read mux; hi bytes expose only bit 8.
  always_comb begin
    rd_data = 8'h00;
    if (idx_q == 4'd0)   rd_data = {pending_q, 5'b0, mode_sh_q};
    else if (slot_valid) rd_data = idx_q[0] ? sh_q[slot][7:0] : {7'b0, sh_q[slot][8]};
  end

  // Combinational read port.
  always_comb begin
    oe   = 1'b0;
    dout = 8'h00;
    if (zxuno_regrd && idx_hit) begin
      oe   = 1'b1;
      dout = {4'b0, idx_q};
    end else if (zxuno_regrd && data_hit) begin
      oe   = 1'b1;
      dout = rd_data;
    end
  end

  assign mode      = mode_q;
  assign pending   = pending_q;
  assign hinit48k  = act_q[0];
  assign vinit48k  = act_q[1];
  assign hinit128k = act_q[2];
  assign vinit128k = act_q[3];
  assign hinitpen  = act_q[4];
  assign vinitpen  = act_q[5];

endmodule
